// File: rtl/replay_issue_buffer_pkg.sv
// Shared definitions for the replay issue buffer: issue width, rollback width
// and the IF->ID packet that flows through the buffer.
package replay_issue_buffer_pkg;

  localparam int WAYS           = 4;
  localparam int ROLLBACK_WIDTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } IF_ID_PACKET;

endpackage

// File: rtl/replay_issue_buffer_ptr_calc.sv
// Combinational pointer arithmetic for the replay issue buffer: how many ways
// are presented, consumed and enqueued, and the next head/tail/count.
module replay_ptr_calc
  import replay_issue_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic [PW-1:0]           head,
  input  logic [PW-1:0]           tail,
  input  logic [CW-1:0]           count,
  input  logic [ROLLBACK_WIDTH:0] rollback,
  input  logic [2:0]              if_count,
  input  logic                    stall,
  input  logic                    squash,
  output logic                    ready,
  output logic [2:0]              presented,
  output logic [2:0]              consumed,
  output logic [2:0]              enqueued,
  output logic [2:0]              rolled_back,
  output logic [PW-1:0]           head_next,
  output logic [PW-1:0]           tail_next,
  output logic [CW-1:0]           count_next
);

  logic [2:0] rb;

  always_comb begin
    rb          = 3'(rollback);
    ready       = (DEPTH - int'(count)) >= WAYS;
    presented   = (count >= CW'(WAYS)) ? 3'(WAYS) : count[2:0];
    // Rollback beyond the presented group clamps so consumed never underflows.
    rolled_back = (rb > presented) ? presented : rb;
    consumed    = (stall || squash) ? 3'd0 : (presented - rolled_back);
    enqueued    = (ready && !squash) ? if_count : 3'd0;

    if (squash) begin
      head_next  = tail;
      tail_next  = tail;
      count_next = '0;
    end else begin
      head_next  = head + PW'(consumed);
      tail_next  = tail + PW'(enqueued);
      count_next = count - CW'(consumed) + CW'(enqueued);
    end
  end

endmodule

// File: rtl/replay_issue_buffer.sv
// IF->ID instruction buffer that re-presents rolled-back ways without re-fetch.
// Optional REPLAY_STATS_EN adds saturating rollback/replay counters.
module replay_issue_buffer
  import replay_issue_buffer_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  IF_ID_PACKET             if_packet_in [WAYS],
  input  logic [2:0]              if_count_in,
  output logic                    if_ready_out,
  input  logic [ROLLBACK_WIDTH:0] rollback,
  input  logic                    id_stall_in,
  input  logic                    squash_in,
  output IF_ID_PACKET             id_packet_out [WAYS],
  output logic [2:0]              id_count_out
`ifdef REPLAY_STATS_EN
  ,
  output logic [31:0]             rollback_events_out,
  output logic [31:0]             replayed_insts_out
`endif
);

  IF_ID_PACKET   mem [DEPTH];
  logic [PW-1:0] head, tail, head_next, tail_next;
  logic [CW-1:0] count, count_next;
  logic [2:0]    presented, consumed, enqueued, rolled_back;

  replay_ptr_calc #(.DEPTH(DEPTH)) u_ptr_calc (
    .head        (head),
    .tail        (tail),
    .count       (count),
    .rollback    (rollback),
    .if_count    (if_count_in),
    .stall       (id_stall_in),
    .squash      (squash_in),
    .ready       (if_ready_out),
    .presented   (presented),
    .consumed    (consumed),
    .enqueued    (enqueued),
    .rolled_back (rolled_back),
    .head_next   (head_next),
    .tail_next   (tail_next),
    .count_next  (count_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

  // Payload storage carries no reset; entries are only read once counted.
  always_ff @(posedge clock) begin
    for (int i = 0; i < WAYS; i++) begin
      if (3'(i) < enqueued) mem[tail + PW'(i)] <= if_packet_in[i];
    end
  end

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      id_packet_out[i] = '0;
      if (3'(i) < presented) begin
        id_packet_out[i]       = mem[head + PW'(i)];
        id_packet_out[i].valid = 1'b1;
      end
    end
    id_count_out = presented;
  end

`ifdef REPLAY_STATS_EN
  logic        rb_event;
  logic [32:0] replay_sum;

  assign rb_event   = !squash_in && !id_stall_in && (rolled_back != 3'd0);
  assign replay_sum = {1'b0, replayed_insts_out} + 33'(rolled_back);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rollback_events_out <= '0;
      replayed_insts_out  <= '0;
    end else if (rb_event) begin
      if (rollback_events_out != '1) rollback_events_out <= rollback_events_out + 32'd1;
      replayed_insts_out <= replay_sum[32] ? '1 : replay_sum[31:0];
    end
  end
`else
  logic [2:0] unused_rolled_back;
  assign unused_rolled_back = rolled_back;
`endif

endmodule

// File: tb/tb_replay_issue_buffer.sv
// Bench for replay_issue_buffer: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based model.
module tb_replay_issue_buffer;
  import replay_issue_buffer_pkg::*;

  localparam int DEPTH = 16;

  logic                    clock = 1'b0;
  logic                    reset;
  IF_ID_PACKET             if_pkt [WAYS];
  logic [2:0]              if_count;
  logic                    if_ready;
  logic [ROLLBACK_WIDTH:0] rollback;
  logic                    stall;
  logic                    squash;
  IF_ID_PACKET             id_pkt [WAYS];
  logic [2:0]              id_count;
`ifdef REPLAY_STATS_EN
  logic [31:0]             rb_events;
  logic [31:0]             replayed;
`endif

  always #5 clock = ~clock;

  replay_issue_buffer #(.DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .if_packet_in  (if_pkt),
    .if_count_in   (if_count),
    .if_ready_out  (if_ready),
    .rollback      (rollback),
    .id_stall_in   (stall),
    .squash_in     (squash),
    .id_packet_out (id_pkt),
    .id_count_out  (id_count)
`ifdef REPLAY_STATS_EN
    ,
    .rollback_events_out (rb_events),
    .replayed_insts_out  (replayed)
`endif
  );

  int          checks = 0;
  int          fails  = 0;
  IF_ID_PACKET mq [$];
  int          exp_events   = 0;
  int          exp_replayed = 0;

  typedef struct {
    int n;
    int pc;
    int rb;
    bit st;
    int exp_cnt;
    int exp_pc0;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the queue model.
  task automatic check_output();
    int          n;
    int          pres;
    IF_ID_PACKET e;
    n    = mq.size();
    pres = (n < WAYS) ? n : WAYS;
    check("id_count", 96'(id_count), 96'(pres));
    check("if_ready", 96'(if_ready), 96'((DEPTH - n) >= WAYS));
    for (int i = 0; i < WAYS; i++) begin
      e = '0;
      if (i < pres) begin
        e       = mq[i];
        e.valid = 1'b1;
      end
      check($sformatf("way%0d", i), 96'(id_pkt[i]), 96'(e));
    end
`ifdef REPLAY_STATS_EN
    check("rb_events", 96'(rb_events), 96'(exp_events));
    check("replayed", 96'(replayed), 96'(exp_replayed));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic apply_stimulus(input int n, input int pc_base, input int rb, input bit st, input bit sq);
    int          pres;
    int          rbe;
    int          cons;
    bit          rdy;
    IF_ID_PACKET incoming [WAYS];
    for (int i = 0; i < WAYS; i++) begin
      incoming[i].pc    = pc_base + 4 * i;
      incoming[i].inst  = $urandom;
      incoming[i].valid = 1'b1;
      if (i >= n) begin
        incoming[i].pc    = $urandom;
        incoming[i].valid = 1'($urandom);
      end
      if_pkt[i] = incoming[i];
    end
    if_count = 3'(n);
    rollback = rb[ROLLBACK_WIDTH:0];
    stall    = st;
    squash   = sq;

    pres = (mq.size() < WAYS) ? mq.size() : WAYS;
    rbe  = (rb < pres) ? rb : pres;
    cons = (st || sq) ? 0 : pres - rbe;
    rdy  = (DEPTH - mq.size()) >= WAYS;
    if (!st && !sq && rbe > 0) begin
      exp_events++;
      exp_replayed += rbe;
    end

    @(posedge clock);
    if (sq) mq.delete();
    else begin
      repeat (cons) mq.delete(0);
      if (rdy) for (int i = 0; i < n; i++) mq.push_back(incoming[i]);
    end
    @(negedge clock);
    check_output();
  endtask

  initial begin
    int rp;
    int n;
    int rb;
    bit st;
    bit sq;
    logic [32:0] ev;

    reset    = 1'b0;
    if_count = '0;
    rollback = '0;
    stall    = 1'b0;
    squash   = 1'b0;
    for (int i = 0; i < WAYS; i++) if_pkt[i] = '0;

    tbl = '{
      '{4,  0, 0, 1'b0, 4,  0},
      '{0,  0, 0, 1'b0, 0,  0},
      '{4,  0, 0, 1'b0, 4,  0},
      '{4, 16, 0, 1'b1, 4,  0},
      '{0,  0, 2, 1'b0, 4,  8},
      '{0,  0, 4, 1'b0, 4,  8},
      '{0,  0, 4, 1'b0, 4,  8},
      '{0,  0, 4, 1'b0, 4,  8},
      '{0,  0, 0, 1'b0, 2, 24},
      '{0,  0, 4, 1'b0, 2, 24},
      '{0,  0, 0, 1'b0, 0,  0}
    };

    #2;
    check("reset_count", 96'(id_count), 96'(0));
    for (int i = 0; i < WAYS; i++) check($sformatf("reset_valid%0d", i), 96'(id_pkt[i].valid), 96'(0));
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("ready_after_reset", 96'(if_ready), 96'(1));

    // Basic flow, partial rollback, repeated full rollback and clamping.
    for (int k = 0; k < 11; k++) begin
      apply_stimulus(tbl[k].n, tbl[k].pc, tbl[k].rb, tbl[k].st, 1'b0);
      check($sformatf("vec%0d_count", k), 96'(id_count), 96'(tbl[k].exp_cnt));
      for (int i = 0; i < WAYS; i++) begin
        ev = (i < tbl[k].exp_cnt) ? {1'b1, 32'(tbl[k].exp_pc0 + 4 * i)} : 33'd0;
        check($sformatf("vec%0d_way%0d", k, i), 96'({id_pkt[i].valid, id_pkt[i].pc}), 96'(ev));
      end
    end

    // Fill to 13 across the index wrap, then drain with a wrapping read window.
    apply_stimulus(4, 200, 0, 1'b1, 1'b0);
    apply_stimulus(4, 216, 0, 1'b1, 1'b0);
    apply_stimulus(4, 232, 0, 1'b1, 1'b0);
    apply_stimulus(1, 248, 0, 1'b1, 1'b0);
    check("full_not_ready", 96'(if_ready), 96'(0));
    apply_stimulus(4, 300, 0, 1'b0, 1'b0);
    check("ready_after_drain", 96'(if_ready), 96'(1));
    check("count_after_drain", 96'(id_count), 96'(4));
    apply_stimulus(4, 320, 0, 1'b0, 1'b0);
    apply_stimulus(4, 340, 0, 1'b0, 1'b0);
    apply_stimulus(0, 0, 1, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 1'b0, 1'b0);
    apply_stimulus(0, 0, 0, 1'b0, 1'b0);

    // Squash beats rollback and drops the same-cycle enqueue.
    apply_stimulus(4, 400, 0, 1'b1, 1'b0);
    apply_stimulus(2, 420, 0, 1'b1, 1'b0);
    apply_stimulus(4, 500, 3, 1'b0, 1'b1);
    check("squash_count", 96'(id_count), 96'(0));
    apply_stimulus(0, 0, 0, 1'b0, 1'b0);
    check("squash_dropped_enq", 96'(id_count), 96'(0));

    // Asynchronous reset in the middle of traffic.
    apply_stimulus(4, 600, 0, 1'b1, 1'b0);
    apply_stimulus(0, 0, 0, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_count", 96'(id_count), 96'(0));
    for (int i = 0; i < WAYS; i++) check($sformatf("midreset_valid%0d", i), 96'(id_pkt[i].valid), 96'(0));
    mq.delete();
    exp_events   = 0;
    exp_replayed = 0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_output();

    apply_stimulus(4, 700, 0, 1'b0, 1'b0);
    apply_stimulus(4, 716, 2, 1'b0, 1'b0);
    apply_stimulus(0, 0, 4, 1'b0, 1'b0);
`ifdef REPLAY_STATS_EN
    check("stats_events", 96'(rb_events), 96'(2));
    check("stats_replayed", 96'(replayed), 96'(6));
`endif

    rp = 1000;
    for (int c = 0; c < 1500; c++) begin
      n  = $urandom_range(0, WAYS);
      rb = $urandom_range(0, WAYS);
      st = ($urandom_range(0, 4) == 0);
      sq = ($urandom_range(0, 19) == 0);
      apply_stimulus(n, rp, rb, st, sq);
      rp += 4 * n;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
